// File: rtl/program_loader_pkg.sv
// Shared loader definitions: session FSM states, header size, memory depth.
// Optional checksum stage: PROGRAM_LOADER_CHECKSUM_EN.
package program_loader_pkg;

  localparam int HEADER_BYTES      = 2;
  localparam int DEFAULT_MEM_DEPTH = 800;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERR
  } loaderState_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    DONE,
    ERR
  } loaderState_t;
`endif

endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes big-endian into 32-bit words; pulses WordReady
// the cycle after the 4th byte. Ports: Clear, Accept, ByteData in;
// LastByte (next accept completes a word), WordReady, Word out.
module word_assembler (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        Clear,
  input  logic        Accept,
  input  logic [7:0]  ByteData,
  output logic        LastByte,
  output logic        WordReady,
  output logic [31:0] Word
);

  logic [23:0] shiftReg;
  logic [1:0]  byteCount;

  assign LastByte = (byteCount == 2'd3);

  // Word is a separate holding register so the next word can
  // start shifting in during the write cycle.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      shiftReg  <= '0;
      byteCount <= '0;
      WordReady <= 1'b0;
      Word      <= '0;
    end else begin
      WordReady <= 1'b0;
      if (Clear) begin
        shiftReg  <= '0;
        byteCount <= '0;
      end else if (Accept) begin
        shiftReg  <= {shiftReg[15:0], ByteData};
        byteCount <= byteCount + 2'd1;
        if (LastByte) begin
          Word      <= {shiftReg, ByteData};
          WordReady <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: 16-bit big-endian word count, then N words
// streamed as bytes into instruction memory. Ports: Start, ByteValid,
// ByteData in; ByteReady, WriteEnable/Address/Data, Busy, LoadDone,
// LoadError out. Optional trailing XOR checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int ADDR_W    = 10
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Start,
  input  logic              ByteValid,
  input  logic [7:0]        ByteData,
  output logic              ByteReady,
  output logic              WriteEnable,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [31:0]       WriteData,
  output logic              Busy,
  output logic              LoadDone,
  output logic              LoadError
);

  localparam int LEN_W = HEADER_BYTES * 8;
  localparam logic [LEN_W-1:0] MaxWords = LEN_W'(MEM_DEPTH);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam loaderState_t FinalState = CHECK;
`else
  localparam loaderState_t FinalState = DONE;
`endif

  loaderState_t state;
  loaderState_t nextState;

  logic [7:0]        lenHi;
  logic [LEN_W-1:0]  lenWord;
  logic [LEN_W-1:0]  wordCount;
  logic [LEN_W-1:0]  wordsIn;
  logic [ADDR_W-1:0] addrCount;
  logic              accept;
  logic              dataAccept;
  logic              lastByte;
  logic              lastWord;
  logic              startSession;
  logic              wordReady;
  logic [31:0]       word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] xorAcc;
`endif

  assign accept     = ByteValid & ByteReady;
  assign dataAccept = accept & (state == DATA);
  assign lenWord    = {lenHi, ByteData};
  assign lastWord   = (wordsIn + LEN_W'(1)) == wordCount;

  assign startSession = Start &
    ((state == IDLE) | (state == DONE) | (state == ERR));

  assign ByteReady = (state == LEN_HI) | (state == LEN_LO) |
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     (state == CHECK) |
`endif
                     (state == DATA);

  assign Busy = ~((state == IDLE) | (state == DONE) |
                  (state == ERR));

  assign LoadDone     = (state == DONE);
  assign LoadError    = (state == ERR);
  assign WriteEnable  = wordReady;
  assign WriteAddress = addrCount;
  assign WriteData    = word;

  word_assembler uAsm (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .Clear    (startSession),
    .Accept   (dataAccept),
    .ByteData (ByteData),
    .LastByte (lastByte),
    .WordReady(wordReady),
    .Word     (word)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (Start) nextState = LEN_HI;
      end
      LEN_HI: begin
        if (accept) nextState = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          if (lenWord > MaxWords)     nextState = ERR;
          else if (lenWord == '0)     nextState = FinalState;
          else                        nextState = DATA;
        end
      end
      DATA: begin
        if (accept && lastByte && lastWord)
          nextState = FinalState;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept)
          nextState = (ByteData == xorAcc) ? DONE : ERR;
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  // A new session clears the counters; the address still advances on
  // the final strobe, which may overlap DONE.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      lenHi     <= '0;
      wordCount <= '0;
      wordsIn   <= '0;
      addrCount <= '0;
    end else if (startSession) begin
      wordsIn   <= '0;
      addrCount <= '0;
    end else begin
      if (accept && state == LEN_HI) lenHi <= ByteData;
      if (accept && state == LEN_LO) wordCount <= lenWord;
      if (dataAccept && lastByte)    wordsIn <= wordsIn + LEN_W'(1);
      if (wordReady)                 addrCount <= addrCount + ADDR_W'(1);
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)           xorAcc <= '0;
    else if (startSession) xorAcc <= '0;
    else if (dataAccept)   xorAcc <= xorAcc ^ ByteData;
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: full-rate load, oversize length,
// empty program, mid-session reset, throttled stream with stray Start.
module tb_program_loader;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        Start = 1'b0;
  logic        ByteValid = 1'b0;
  logic [7:0]  ByteData = 8'h00;
  logic        ByteReady;
  logic        WriteEnable;
  logic [9:0]  WriteAddress;
  logic [31:0] WriteData;
  logic        Busy;
  logic        LoadDone;
  logic        LoadError;

  program_loader #(.MEM_DEPTH(800), .ADDR_W(10)) dut (
    .Clock       (Clock),
    .ResetN      (ResetN),
    .Start       (Start),
    .ByteValid   (ByteValid),
    .ByteData    (ByteData),
    .ByteReady   (ByteReady),
    .WriteEnable (WriteEnable),
    .WriteAddress(WriteAddress),
    .WriteData   (WriteData),
    .Busy        (Busy),
    .LoadDone    (LoadDone),
    .LoadError   (LoadError)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  logic [9:0]  wrAddr [64];
  logic [31:0] wrData [64];
  int          wrCount = 0;
  int          base;
  logic [7:0]  stream [$];
  logic [7:0]  csum;

  always @(negedge Clock) begin
    if (WriteEnable && wrCount < 64) begin
      wrAddr[wrCount] = WriteAddress;
      wrData[wrCount] = WriteData;
      wrCount = wrCount + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulseStart();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Called at a negedge; returns at a negedge after the last accept.
  task automatic sendStream(input int maxGap, input int startAt);
    int gap;
    int n;
    for (int i = 0; i < stream.size(); i++) begin
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      if (gap > 0) begin
        ByteValid = 1'b0;
        repeat (gap) @(negedge Clock);
      end
      if (i == startAt) begin
        ByteValid = 1'b0;
        pulseStart();
      end
      ByteData = stream[i];
      ByteValid = 1'b1;
      n = 0;
      while (!ByteReady && n < 50) begin
        @(negedge Clock);
        n++;
      end
      if (!ByteReady) begin
        chk("ready_timeout", {31'd0, ByteReady}, 32'd1);
        ByteValid = 1'b0;
        return;
      end
      @(negedge Clock);
    end
    ByteValid = 1'b0;
  endtask

  task automatic mainStream(input logic [7:0] chkXor);
    stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
               8'h00, 8'h00, 8'h00, 8'h01};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    stream.push_back(chkXor);
`else
    if (chkXor != 8'h00) stream.push_back(chkXor);
`endif
  endtask

  task automatic checkTwoWords(input string tag);
    chk({tag, "_count"}, wrCount - base, 2);
    chk({tag, "_a0"}, {22'd0, wrAddr[base]}, 32'd0);
    chk({tag, "_d0"}, wrData[base], 32'hDEADBEEF);
    chk({tag, "_a1"}, {22'd0, wrAddr[base+1]}, 32'd1);
    chk({tag, "_d1"}, wrData[base+1], 32'h00000001);
  endtask

  initial begin
    csum = 8'h00;
    mainStream(8'h00);
    for (int i = 2; i < 10; i++) csum = csum ^ stream[i];

    #2;
    chk("rst_ready", {31'd0, ByteReady}, 32'd0);
    chk("rst_we",    {31'd0, WriteEnable}, 32'd0);
    chk("rst_busy",  {31'd0, Busy}, 32'd0);
    chk("rst_done",  {31'd0, LoadDone}, 32'd0);
    chk("rst_err",   {31'd0, LoadError}, 32'd0);
    chk("rst_addr",  {22'd0, WriteAddress}, 32'd0);
    chk("rst_data",  WriteData, 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    idle(1);

    // full-rate two-word load
    base = wrCount;
    pulseStart();
    chk("s1_busy_hdr", {31'd0, Busy}, 32'd1);
    chk("s1_ready_hdr", {31'd0, ByteReady}, 32'd1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    mainStream(csum);
`else
    mainStream(8'h00);
`endif
    sendStream(0, -1);
    idle(3);
    checkTwoWords("s1");
    chk("s1_done", {31'd0, LoadDone}, 32'd1);
    chk("s1_err",  {31'd0, LoadError}, 32'd0);
    chk("s1_busy", {31'd0, Busy}, 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // wrong checksum still writes both words
    base = wrCount;
    pulseStart();
    mainStream(csum ^ 8'h01);
    sendStream(0, -1);
    idle(3);
    checkTwoWords("bad_sum");
    chk("bad_sum_err",  {31'd0, LoadError}, 32'd1);
    chk("bad_sum_done", {31'd0, LoadDone}, 32'd0);
`endif

    // 801 words exceeds depth
    base = wrCount;
    pulseStart();
    chk("big_done_clr", {31'd0, LoadDone}, 32'd0);
    stream = '{8'h03, 8'h21};
    sendStream(0, -1);
    idle(3);
    chk("big_err",   {31'd0, LoadError}, 32'd1);
    chk("big_done",  {31'd0, LoadDone}, 32'd0);
    chk("big_busy",  {31'd0, Busy}, 32'd0);
    chk("big_nowr",  wrCount - base, 0);

    // empty program
    base = wrCount;
    pulseStart();
    chk("empty_err_clr", {31'd0, LoadError}, 32'd0);
    stream = '{8'h00, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    sendStream(0, -1);
    idle(3);
    chk("empty_done", {31'd0, LoadDone}, 32'd1);
    chk("empty_err",  {31'd0, LoadError}, 32'd0);
    chk("empty_nowr", wrCount - base, 0);

    // reset after two data bytes
    base = wrCount;
    pulseStart();
    stream = '{8'h00, 8'h01, 8'hDE, 8'hAD};
    sendStream(0, -1);
    ResetN = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ByteReady}, 32'd0);
    chk("mid_rst_busy",  {31'd0, Busy}, 32'd0);
    chk("mid_rst_we",    {31'd0, WriteEnable}, 32'd0);
    chk("mid_rst_done",  {31'd0, LoadDone}, 32'd0);
    chk("mid_rst_err",   {31'd0, LoadError}, 32'd0);
    chk("mid_rst_addr",  {22'd0, WriteAddress}, 32'd0);
    chk("mid_rst_data",  WriteData, 32'd0);
    idle(2);
    ResetN = 1'b1;
    idle(1);
    chk("mid_rst_nowr", wrCount - base, 0);
    pulseStart();
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    stream.push_back(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
`endif
    sendStream(0, -1);
    idle(3);
    chk("post_rst_count", wrCount - base, 1);
    chk("post_rst_a0", {22'd0, wrAddr[base]}, 32'd0);
    chk("post_rst_d0", wrData[base], 32'h12345678);
    chk("post_rst_done", {31'd0, LoadDone}, 32'd1);

    // throttled stream with a stray Start mid-data
    base = wrCount;
    pulseStart();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    mainStream(csum);
`else
    mainStream(8'h00);
`endif
    sendStream(2, 5);
    idle(3);
    checkTwoWords("thr");
    chk("thr_done", {31'd0, LoadDone}, 32'd1);
    chk("thr_busy", {31'd0, Busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
